noc_switch_alloc: RTL and testbench

Parametrised switch allocator for a 5-port mesh router (N, S, E, W, Local). Computes a dimension-ordered route for the head flit at each input and arbitrates each output fairly among requesting inputs. Unlike the previous controller, grants are held for the whole multi-flit packet (wormhole lock), backpressure uses per-output credit counters instead of a full flag, and the routing order and address width are parameters. Sits between the input buffers and the crossbar. It drives crossbar selects and input dequeue strobes.

---
 rtl/noc_pkg.sv | 42 ++++
 rtl/noc_switch_alloc_rr_lock_arb.sv | 100 ++++++++++
 rtl/noc_switch_alloc.sv | 102 ++++++++++
 tb/tb_noc_switch_alloc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types for the mesh router switch allocator.
// Port enum, lock state encoding, owner type and the route function.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef logic [2:0] owner_t;
  typedef logic state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_LOCKED = 1'b1;

  // Dimension-ordered route; coordinates arrive zero-extended.
  // yx=0 resolves X first, yx=1 resolves Y first.
  function automatic port_e route_f(
    input logic [15:0] dx,
    input logic [15:0] lx,
    input logic [15:0] dy,
    input logic [15:0] ly,
    input logic        yx
  );
    port_e px;
    port_e py;
    px = PORT_L;
    py = PORT_L;
    if (dx > lx) px = PORT_E;
    else if (dx < lx) px = PORT_W;
    if (dy > ly) py = PORT_N;
    else if (dy < ly) py = PORT_S;
    if (yx) return (py != PORT_L) ? py : px;
    return (px != PORT_L) ? px : py;
  endfunction

endpackage

// File: rtl/noc_switch_alloc_rr_lock_arb.sv
// Per-output arbiter: round-robin pick, wormhole lock, credit count.
// req/valid/tail per input in; grant one-hot, grant_v, lock state out.
module rr_lock_arb
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] valid,
  input  logic [4:0] tail,
  input  logic       credit_ret,
  output logic [4:0] grant,
  output logic       grant_v,
  output logic       locked,
  output logic [2:0] owner
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  owner_t        own;
  owner_t        ptr;
  logic [CW-1:0] cnt;

  logic       found;
  owner_t     win;
  logic [3:0] sum;
  owner_t     idx;
  logic       gv;
  logic [4:0] gsel;
  logic       xfer;

  always_comb begin
    found = 1'b0;
    win   = ptr;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gv   = 1'b0;
    gsel = '0;
    if (state == ST_LOCKED) begin
      if (valid[own] && cnt != '0) begin
        gv        = 1'b1;
        gsel[own] = 1'b1;
      end
    end else if (found && cnt != '0) begin
      gv        = 1'b1;
      gsel[win] = 1'b1;
    end
  end

  // Outputs are held quiet for as long as reset is low.
  assign grant_v = rst & gv;
  assign grant   = rst ? gsel : '0;
  assign xfer    = grant_v;
  assign locked  = (state == ST_LOCKED);
  assign owner   = own;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      own   <= '0;
      ptr   <= '0;
      cnt   <= FULL;
    end else begin
      if (xfer) begin
        if (state == ST_IDLE) begin
          ptr <= (win == 3'd4) ? 3'd0 : win + 3'd1;
          if (!tail[win]) begin
            state <= ST_LOCKED;
            own   <= win;
          end
        end else if (tail[own]) begin
          state <= ST_IDLE;
        end
      end
      if (xfer && !credit_ret) begin
        cnt <= cnt - 1'b1;
      end else if (!xfer && credit_ret && cnt != FULL) begin
        cnt <= cnt + 1'b1;
      end
      assert (!(!xfer && credit_ret && cnt == FULL))
        else $error("credit return with counter already full");
    end
  end

endmodule

// File: rtl/noc_switch_alloc.sv
// Switch allocator for a 5-port mesh router (N,S,E,W,L).
// Routes head flits, checks U-turns, drives grant/grant_v/in_ack/route_err.
module noc_switch_alloc
  import noc_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 4,
  parameter int ROUTE_YX = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      local_addr,
  input  logic [4:0][ADDR_W-1:0] packet_addr,
  input  logic [4:0]             packet_valid,
  input  logic [4:0]             packet_tail,
  input  logic [4:0]             credit_ret,
  output logic [4:0][4:0]        grant,
  output logic [4:0]             grant_v,
  output logic [4:0]             in_ack,
  output logic                   route_err
);

  localparam int HW = ADDR_W / 2;
  localparam logic YX = (ROUTE_YX != 0);

  port_e      route [5];
  logic [4:0] uturn;
  logic [4:0] lock_in;
  logic [4:0] head;
  logic [4:0][4:0] req;
  logic [4:0] lock_o;
  owner_t     own_o [5];
  logic       err_set;

  logic [15:0] lx;
  logic [15:0] ly;

  assign lx = 16'(local_addr[ADDR_W-1:HW]);
  assign ly = 16'(local_addr[HW-1:0]);

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = route_f(
        16'(packet_addr[i][ADDR_W-1:HW]), lx,
        16'(packet_addr[i][HW-1:0]), ly, YX);
      uturn[i] = (i != NUM_PORTS - 1) &&
                 (route[i] == port_e'(3'(i)));
    end
  end

  // An input already owning an output sends body flits;
  // its address is stale and must not raise new requests.
  always_comb begin
    lock_in = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock_o[o]) lock_in[own_o[o]] = 1'b1;
    end
  end

  assign head    = packet_valid & ~lock_in;
  assign err_set = |(head & uturn);

  always_comb begin
    req = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = head[i] && !uturn[i] &&
                    (route[i] == port_e'(3'(o)));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    rr_lock_arb #(
      .DEPTH(DEPTH)
    ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req[o]),
      .valid     (packet_valid),
      .tail      (packet_tail),
      .credit_ret(credit_ret[o]),
      .grant     (grant[o]),
      .grant_v   (grant_v[o]),
      .locked    (lock_o[o]),
      .owner     (own_o[o])
    );
  end

  always_comb begin
    in_ack = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_ack = in_ack | (grant[o] & {5{grant_v[o]}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) route_err <= 1'b0;
    else if (err_set) route_err <= 1'b1;
  end

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed bench for noc_switch_alloc: XY, YX and DEPTH=2 instances.
// Checks routing, round robin, wormhole lock, credits, U-turn, reset.
module tb_noc_switch_alloc;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      laddr;
  logic [4:0][7:0] paddr;
  logic [4:0]      pv;
  logic [4:0]      pt;
  logic [4:0]      cr_a;
  logic [4:0]      cr_d;
  logic [4:0]      cr_y;

  logic [4:0][4:0] g_a, g_y, g_d;
  logic [4:0]      gv_a, gv_y, gv_d;
  logic [4:0]      ack_a, ack_y, ack_d;
  logic            err_a, err_y, err_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_switch_alloc dut (
    .clk(clk), .rst(rst), .local_addr(laddr),
    .packet_addr(paddr), .packet_valid(pv),
    .packet_tail(pt), .credit_ret(cr_a),
    .grant(g_a), .grant_v(gv_a), .in_ack(ack_a),
    .route_err(err_a)
  );

  noc_switch_alloc #(.ROUTE_YX(1)) dut_yx (
    .clk(clk), .rst(rst), .local_addr(laddr),
    .packet_addr(paddr), .packet_valid(pv),
    .packet_tail(pt), .credit_ret(cr_y),
    .grant(g_y), .grant_v(gv_y), .in_ack(ack_y),
    .route_err(err_y)
  );

  noc_switch_alloc #(.DEPTH(2)) dut_d2 (
    .clk(clk), .rst(rst), .local_addr(laddr),
    .packet_addr(paddr), .packet_valid(pv),
    .packet_tail(pt), .credit_ret(cr_d),
    .grant(g_d), .grant_v(gv_d), .in_ack(ack_d),
    .route_err(err_d)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pv    = '0;
    pt    = '0;
    paddr = '0;
    cr_a  = '0;
    cr_d  = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [4:0] exp_rr [4];

  initial begin
    exp_rr = '{5'b00010, 5'b01000, 5'b10000, 5'b00010};
    cr_y  = '0;
    laddr = 8'h22;
    clr();
    rst = 1'b0;

    // reset with a pending L flit to E
    pv = 5'b10000;
    pt = 5'b10000;
    paddr[4] = 8'h52;
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(g_a), 32'h0);
    chk("rst_gv", 32'(gv_a), 32'h0);
    chk("rst_ack", 32'(ack_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("xy_grantE", 32'(g_a[2]), 32'h10);
    chk("xy_gv", 32'(gv_a), 32'h04);
    chk("xy_ack", 32'(ack_a), 32'h10);
    chk("yx_52_gv", 32'(gv_y), 32'h04);
    tick();
    paddr[4] = 8'h53;
    @(negedge clk);
    chk("yx_53_gv", 32'(gv_y), 32'h01);
    chk("yx_53_grantN", 32'(g_y[0]), 32'h10);
    chk("xy_53_gv", 32'(gv_a), 32'h04);

    // round robin on N among S, W, L
    do_reset();
    pv = 5'b11010;
    pt = 5'b11010;
    paddr[1] = 8'h23;
    paddr[3] = 8'h23;
    paddr[4] = 8'h23;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", c), 32'(g_a[0]),
          32'(exp_rr[c]));
      chk($sformatf("rr_ack%0d", c), 32'(ack_a),
          32'(exp_rr[c]));
      tick();
    end

    // wormhole: L 3-flit packet to E, W waiting
    do_reset();
    pv = 5'b10000;
    paddr[4] = 8'h52;
    @(negedge clk);
    chk("wh_head", 32'(g_a[2]), 32'h10);
    tick();
    pv = 5'b11000;
    pt = 5'b01000;
    paddr[3] = 8'h52;
    paddr[4] = 8'h02;
    @(negedge clk);
    chk("wh_body", 32'(g_a[2]), 32'h10);
    chk("wh_body_gv", 32'(gv_a), 32'h04);
    tick();
    pv = 5'b01000;
    @(negedge clk);
    chk("wh_bubble", 32'(gv_a), 32'h0);
    tick();
    pv = 5'b11000;
    pt = 5'b11000;
    @(negedge clk);
    chk("wh_tail", 32'(g_a[2]), 32'h10);
    tick();
    pv = 5'b01000;
    @(negedge clk);
    chk("wh_w_wins", 32'(g_a[2]), 32'h08);
    tick();

    // credits, DEPTH=2, single-flit packets L->N
    do_reset();
    pv = 5'b10000;
    pt = 5'b10000;
    paddr[4] = 8'h23;
    @(negedge clk);
    chk("cr_g1", 32'(gv_d[0]), 32'h1);
    tick();
    @(negedge clk);
    chk("cr_g2", 32'(gv_d[0]), 32'h1);
    tick();
    cr_d = 5'b00001;
    @(negedge clk);
    chk("cr_stall", 32'(gv_d[0]), 32'h0);
    tick();
    cr_d = '0;
    @(negedge clk);
    chk("cr_after_ret", 32'(gv_d[0]), 32'h1);
    tick();
    cr_d = 5'b00001;
    @(negedge clk);
    chk("cr_zero_ret", 32'(gv_d[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("cr_xfer_ret", 32'(gv_d[0]), 32'h1);
    tick();
    cr_d = '0;
    @(negedge clk);
    chk("cr_kept", 32'(gv_d[0]), 32'h1);
    tick();
    @(negedge clk);
    chk("cr_empty", 32'(gv_d[0]), 32'h0);
    tick();

    // U-turn on E input
    do_reset();
    pv = 5'b00100;
    pt = 5'b00100;
    paddr[2] = 8'h52;
    @(negedge clk);
    chk("ut_gv", 32'(gv_a), 32'h0);
    chk("ut_ack", 32'(ack_a), 32'h0);
    tick();
    pv = '0;
    @(negedge clk);
    chk("ut_err", 32'(err_a), 32'h1);
    tick();
    tick();
    @(negedge clk);
    chk("ut_err_sticky", 32'(err_a), 32'h1);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("ut_err_clr", 32'(err_a), 32'h0);
    tick();
    rst = 1'b1;

    // reset in the middle of a locked packet
    do_reset();
    pv = 5'b10000;
    paddr[4] = 8'h52;
    @(negedge clk);
    chk("mr_lock", 32'(g_a[2]), 32'h10);
    tick();
    rst = 1'b0;
    pv = 5'b11000;
    pt = 5'b01000;
    paddr[3] = 8'h52;
    @(negedge clk);
    chk("mr_grant0", 32'(g_a), 32'h0);
    chk("mr_gv0", 32'(gv_a), 32'h0);
    chk("mr_ack0", 32'(ack_a), 32'h0);
    tick();
    rst = 1'b1;
    pv = 5'b01000;
    @(negedge clk);
    chk("mr_w_wins", 32'(g_a[2]), 32'h08);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr_cr%0d", c), 32'(gv_a[2]), 32'h1);
      tick();
    end
    @(negedge clk);
    chk("mr_cr_out", 32'(gv_a[2]), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
